// File: rtl/ft2232h_pkg.sv
// Shared definitions for the FT2232H TX arbiter: header tag, FSM encoding
// and a constant clog2 helper used to size channel indices.
package ft2232h_pkg;

  localparam logic [3:0] FT_HDR_TAG = 4'hA;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_FLUSH = 3'd4
  } ft_state_e;

  // Ceiling log2, valid for v >= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/ft2232h_tx_arbiter_rr_arbiter.sv
// Combinational round-robin pick.
//   req     : per-channel request vector
//   ptr     : index of the last winner; the scan starts at ptr+1 and wraps
//   found_c : at least one request is set
//   idx_c   : index of the first requester after ptr
module rr_arbiter
  import ft2232h_pkg::*;
#(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned PW     = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic              found_c,
  output logic [PW-1:0]     idx_c
);

  logic [PW-1:0] cand;

  // Lowest offset from ptr wins, so the previous winner comes last.
  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    cand    = '0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      cand = PW'((32'(ptr) + k) % NUM_CH);
      if (!found_c && req[cand]) begin
        found_c = 1'b1;
        idx_c   = cand;
      end
    end
  end

endmodule

// File: rtl/ft2232h_tx_arbiter.sv
// Packet-level round-robin arbiter driving the FT2232H synchronous-FIFO TX port.
//   clk, reset_n          : comm clock, async active-low reset
//   req_valid/data/last   : per-channel byte streams (ch i at req_data[8*i+:8])
//   req_ready             : byte taken this cycle
//   txe_n                 : FT2232H TXE#, low = FIFO can accept
//   wr_n, data, siwu_n    : registered FT2232H pins; rd_n/oe_n tied high
//   grant, busy, pkt_done : current owner, FSM active, last byte accepted
module ft2232h_tx_arbiter
  import ft2232h_pkg::*;
#(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned HDR_EN  = 1,
  parameter int unsigned SIWU_EN = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NUM_CH-1:0]     req_valid,
  input  logic [8*NUM_CH-1:0]   req_data,
  input  logic [NUM_CH-1:0]     req_last,
  output logic [NUM_CH-1:0]     req_ready,
  input  logic                  txe_n,
  output logic                  wr_n,
  output logic [7:0]            data,
  output logic                  siwu_n,
  output logic                  rd_n,
  output logic                  oe_n,
  output logic [NUM_CH-1:0]     grant,
  output logic                  busy,
  output logic                  pkt_done
);

  localparam int unsigned PW = clog2(NUM_CH);

  ft_state_e           state_q, state_d;
  logic [PW-1:0]       gidx_q, gidx_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [NUM_CH-1:0]   grant_q, grant_d;
  logic                wr_n_q, wr_n_d;
  logic [7:0]          data_q, data_d;
  logic                siwu_n_q, siwu_n_d;
  logic                busy_q, busy_d;

  logic [7:0]          ch_data [NUM_CH];
  logic                pick_found;
  logic [PW-1:0]       pick_idx;
  logic                accept;
  logic                load_ok;
  logic                take;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign ch_data[i] = req_data[8*i +: 8];
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .PW     (PW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .found_c (pick_found),
    .idx_c   (pick_idx)
  );

  // Output register is full while wr_n is low; it may reload on the accepting edge.
  assign accept  = ~wr_n_q & ~txe_n;
  assign load_ok = wr_n_q | accept;
  assign take    = (state_q == ST_DATA) & req_valid[gidx_q] & load_ok;

  // Only the owner is ever handshaken.
  always_comb begin
    req_ready         = '0;
    req_ready[gidx_q] = take;
  end

  assign pkt_done = (state_q == ST_DRAIN) & accept;

  // Next-state and output-stage logic.
  always_comb begin
    state_d  = state_q;
    gidx_d   = gidx_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    wr_n_d   = accept ? 1'b1 : wr_n_q;
    data_d   = data_q;
    siwu_n_d = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        grant_d = '0;
        if (pick_found) begin
          gidx_d            = pick_idx;
          rr_ptr_d          = pick_idx;
          grant_d[pick_idx] = 1'b1;
          state_d           = (HDR_EN != 0) ? ST_HDR : ST_DATA;
        end
      end
      ST_HDR: begin
        if (load_ok) begin
          wr_n_d  = 1'b0;
          data_d  = {FT_HDR_TAG, 4'(gidx_q)};
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (take) begin
          wr_n_d = 1'b0;
          data_d = ch_data[gidx_q];
          if (req_last[gidx_q]) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (accept) begin
          if (SIWU_EN != 0) begin
            state_d  = ST_FLUSH;
            siwu_n_d = 1'b0;
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end
      ST_FLUSH: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // Register bank; reset drops any packet in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      gidx_q   <= '0;
      rr_ptr_q <= PW'(NUM_CH - 1);
      grant_q  <= '0;
      wr_n_q   <= 1'b1;
      data_q   <= 8'h00;
      siwu_n_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gidx_q   <= gidx_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      wr_n_q   <= wr_n_d;
      data_q   <= data_d;
      siwu_n_q <= siwu_n_d;
      busy_q   <= busy_d;
    end
  end

  assign wr_n   = wr_n_q;
  assign data   = data_q;
  assign siwu_n = siwu_n_q;
  assign grant  = grant_q;
  assign busy   = busy_q;
  assign rd_n   = 1'b1;
  assign oe_n   = 1'b1;

endmodule
